// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device transmitter. Sends one command byte over the open-drain PS/2
// lines via active-high pull-low enables and reports the device ACK or a timeout.
module ps2_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int CW = $clog2((TIMEOUT_CYC > INHIBIT_CYC ? TIMEOUT_CYC : INHIBIT_CYC) + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE, ERR} state_t;
  state_t state;
  logic [2:0] clk_sync;
  logic [1:0] data_sync;
  logic [9:0] sh;
  logic [3:0] bitcnt;
  logic [CW-1:0] cnt;
  logic clk_s, data_s, fall, timeout, to_err;
  assign clk_s = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall = clk_sync[2] & ~clk_sync[1];
  assign timeout = cnt == CW'(TIMEOUT_CYC - 1);
  // A timeout coinciding with a device edge is not a timeout; a clean bus beats a timeout in WAIT_IDLE.
  assign to_err = ((state == RTS || state == DATA || state == ACK) && timeout && !fall)
               || (state == ACK && fall && data_s)
               || (state == WAIT_IDLE && timeout && !(clk_s && data_s));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      clk_sync <= '1;
      data_sync <= '1;
      sh <= '0;
      bitcnt <= '0;
      cnt <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      done <= 1'b0;
      err <= 1'b0;
      cnt <= fall ? '0 : cnt + CW'(1);
      case (state)
        IDLE: if (tx_start && !busy && !done) begin
          sh <= {1'b1, ~^tx_data, tx_data};
          busy <= 1'b1;
          ps2_clk_oe <= 1'b1;
          cnt <= '0;
          state <= INHIBIT;
        end
        INHIBIT: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(INHIBIT_CYC - 2)) ps2_data_oe <= 1'b1;
          if (cnt == CW'(INHIBIT_CYC - 1)) begin
            ps2_clk_oe <= 1'b0;
            cnt <= '0;
            state <= RTS;
          end
        end
        RTS, DATA: if (fall) begin
          ps2_data_oe <= ~sh[0];
          sh <= {1'b1, sh[9:1]};
          bitcnt <= state == RTS ? 4'd1 : bitcnt + 4'd1;
          if (state == DATA && bitcnt == 4'd9) state <= ACK;
          else state <= DATA;
        end
        ACK: if (fall && !data_s) begin
          cnt <= '0;
          state <= WAIT_IDLE;
        end
        WAIT_IDLE: if (clk_s && data_s) begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (to_err) begin
        err <= 1'b1;
        busy <= 1'b0;
        ps2_clk_oe <= 1'b0;
        ps2_data_oe <= 1'b0;
        cnt <= '0;
        state <= ERR;
      end
    end
  end
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed sends against a PS/2 device model; a monitor scores done/err pulses
// against queued expectations and watches inhibit timing and line drive.
module tb_ps2_tx;
  localparam int INH = 25;
  localparam int TMO = 300;
  localparam int H = 20;
  logic clk = 1'b0, rst_n = 1'b0, tx_start = 1'b0;
  logic [7:0] tx_data = '0;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe, busy, done, err;
  int vectors = 0, miscompares = 0;
  int kind_q[$];
  logic [10:0] frame_q[$];
  logic [10:0] cap = '0;
  assign ps2_clk = dev_clk & ~ps2_clk_oe;
  assign ps2_data = dev_data & ~ps2_data_oe;
  always #5 clk = ~clk;
  ps2_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(ps2_clk), .ps2_data_in(ps2_data), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .err(err)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // kind: 0 = ACKed (done), 1 = NACK (err), 2 = timeout (err)
  initial begin
    int since = 0, run = 0, ovl = 0, k;
    logic pco = 1'b0, pbusy = 1'b0;
    logic [10:0] f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0; ovl = 0; pco = 1'b0; pbusy = 1'b0;
        continue;
      end
      since = (pco && !ps2_clk_oe) ? 0 : since + 1;
      pco = ps2_clk_oe;
      if (ps2_clk_oe) begin
        run++;
        if (ps2_data_oe) ovl++;
      end else if (run > 0) begin
        check("inhibit_len", run, INH);
        check("inhibit_overlap", ovl, 1);
        run = 0; ovl = 0;
      end
      if (done && err) check("done_err_exclusive", 1, 0);
      if (done || err) begin
        if (kind_q.size() == 0) check("unexpected_pulse", {done, err}, 0);
        else begin
          k = kind_q.pop_front();
          f = frame_q.pop_front();
          check("outcome_done", done, k == 0);
          check("busy_drop", busy, 0);
          check("busy_span", pbusy, 1);
          if (k != 2) check("frame", cap, f);
          if (k == 2) check("timeout_cyc", since, TMO);
          if (err) check("oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
        end
      end
      pbusy = busy;
    end
  end
  // mode: 0 ACK, 1 NACK, 2 silent, 3 reset during bit 4
  task automatic device(input int mode, input bit mid_start);
    int t = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      check("rts_wait", 0, 1);
      return;
    end
    cap = '0;
    cap[0] = ps2_data;
    if (mode == 2) return;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      dev_clk = 1'b0;
      for (int i = 0; i < H; i++) begin
        @(negedge clk);
        if (mid_start && k == 3 && i == 2) begin
          tx_data = 8'h55;
          tx_start = 1'b1;
        end else tx_start = 1'b0;
      end
      if (mode == 3 && k == 4) begin
        rst_n = 1'b0;
        #1;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        dev_clk = 1'b1;
        return;
      end
      dev_clk = 1'b1;
      if (k < 10) cap[k+1] = ps2_data;
      if (k == 9 && mode == 0) dev_data = 1'b0;
      if (k == 10) dev_data = 1'b1;
      repeat (H) @(negedge clk);
    end
  endtask
  task automatic send(input logic [7:0] d, input int mode, input logic [10:0] f, input bit mid_start);
    int t = 0;
    if (mode != 3) begin
      kind_q.push_back(mode);
      frame_q.push_back(f);
    end
    @(negedge clk);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_rise", busy, 1);
    device(mode, mid_start);
    if (mode == 3) begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
    end else begin
      while (busy && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (busy) check("busy_wait", busy, 0);
    end
    repeat (5) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'hED, 0, 11'b1_1_1110_1101_0, 1'b0);
    send(8'h00, 0, 11'b1_1_0000_0000_0, 1'b0);
    send(8'hFF, 0, 11'b1_1_1111_1111_0, 1'b0);
    send(8'h01, 0, 11'b1_0_0000_0001_0, 1'b0);
    send(8'hED, 2, 11'b0, 1'b0);
    send(8'hA5, 1, 11'b1_1_1010_0101_0, 1'b0);
    send(8'hE3, 3, 11'b0, 1'b0);
    send(8'hF4, 0, 11'b1_0_1111_0100_0, 1'b0);
    send(8'h12, 0, 11'b1_1_0001_0010_0, 1'b1);
    check("queue_empty", kind_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
